// File: rtl/wb_fuzz_driver.sv
// Wishbone dual-bridge fuzz driver: LFSR write bursts,
// read-back of the same address and compare.
module wb_fuzz_driver #(
    parameter int                ADDR_WIDTH     = 32,
    parameter int                DATA_WIDTH     = 32,
    parameter int                EXT_RW_WIDTH   = 256,
    parameter logic [31:0]       ADDR_BASE      = 32'h3000_0000,
    parameter logic [31:0]       ADDR_MASK      = 32'h0000_0FFF,
    parameter int                TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             seed,
    input  logic [15:0]             num_pairs,
    output logic                    ext_master_req,
    output logic                    ext_master_we,
    output logic [ADDR_WIDTH-1:0]   ext_master_addr_write,
    output logic [ADDR_WIDTH-1:0]   ext_master_addr_read,
    output logic [EXT_RW_WIDTH-1:0] ext_master_wdata,
    input  logic [EXT_RW_WIDTH-1:0] ext_master_rdata,
    input  logic                    ext_master_write_done,
    input  logic                    ext_master_read_done,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             pass_count,
    output logic [15:0]             mismatch_count,
    output logic [ADDR_WIDTH-1:0]   first_fail_addr,
    output logic                    timeout
);

    localparam int BURST_LEN = EXT_RW_WIDTH / DATA_WIDTH;
    localparam int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int CNT_W     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GEN      = 3'd1;
    localparam logic [2:0] S_WR_ISSUE = 3'd2;
    localparam logic [2:0] S_WR_WAIT  = 3'd3;
    localparam logic [2:0] S_RD_ISSUE = 3'd4;
    localparam logic [2:0] S_RD_WAIT  = 3'd5;
    localparam logic [2:0] S_CHECK    = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    logic [2:0]              state;
    logic [31:0]             lfsr;
    logic [31:0]             lfsr_next;
    logic [15:0]             pairs_left;
    logic [BEAT_W-1:0]       beat;
    logic [CNT_W-1:0]        wait_cnt;
    logic [EXT_RW_WIDTH-1:0] wdata_q;
    logic [EXT_RW_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    match;
    logic                    wait_expired;

    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    assign ext_master_req = (state == S_WR_ISSUE) || (state == S_RD_ISSUE);
    assign ext_master_we  = (state == S_WR_ISSUE) || (state == S_WR_WAIT);
    assign ext_master_addr_write = addr_q;
    assign ext_master_addr_read  = addr_q;
    assign ext_master_wdata      = wdata_q;

    // Read beats come back in reverse order; compare beat-reversed.
    always_comb begin
        match = 1'b1;
        for (int i = 0; i < BURST_LEN; i++) begin
            if (rdata_q[(BURST_LEN-1-i)*DATA_WIDTH +: DATA_WIDTH] !=
                wdata_q[i*DATA_WIDTH +: DATA_WIDTH])
                match = 1'b0;
        end
    end

    // Sequencer: generate, write, wait, read, wait, compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            lfsr            <= 32'h1;
            pairs_left      <= '0;
            beat            <= '0;
            wait_cnt        <= '0;
            wdata_q         <= '0;
            rdata_q         <= '0;
            addr_q          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass_count      <= '0;
            mismatch_count  <= '0;
            first_fail_addr <= '0;
            timeout         <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        lfsr            <= (seed == 32'h0) ? 32'h1 : seed;
                        pairs_left      <= num_pairs;
                        beat            <= '0;
                        pass_count      <= '0;
                        mismatch_count  <= '0;
                        first_fail_addr <= '0;
                        timeout         <= 1'b0;
                        if (num_pairs == 16'h0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            state <= S_GEN;
                        end
                    end
                end
                S_GEN: begin
                    lfsr <= lfsr_next;
                    wdata_q[beat*DATA_WIDTH +: DATA_WIDTH] <= lfsr_next;
                    if (beat == BEAT_W'(BURST_LEN - 1)) begin
                        beat   <= '0;
                        addr_q <= ADDR_WIDTH'(ADDR_BASE |
                                  (lfsr_next & ADDR_MASK & ~32'h1F));
                        state  <= S_WR_ISSUE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                S_WR_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (ext_master_write_done) begin
                        state <= S_RD_ISSUE;
                    end else if (wait_expired) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RD_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (ext_master_read_done) begin
                        rdata_q <= ext_master_rdata;
                        state   <= S_CHECK;
                    end else if (wait_expired) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (match) begin
                        pass_count <= pass_count + 1'b1;
                    end else begin
                        if (mismatch_count == 16'h0)
                            first_fail_addr <= addr_q;
                        if (mismatch_count != 16'hFFFF)
                            mismatch_count <= mismatch_count + 1'b1;
                    end
                    pairs_left <= pairs_left - 1'b1;
                    if (pairs_left == 16'd1) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_GEN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_fuzz_driver.sv
// Bench for wb_fuzz_driver: bridge/memory model,
// vector table of runs plus timeout, reset and start corners.
module tb_wb_fuzz_driver;

    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [31:0]  seed_i = '0;
    logic [15:0]  num_pairs_i = '0;
    logic         req;
    logic         we;
    logic [31:0]  addr_w;
    logic [31:0]  addr_r;
    logic [255:0] wdata;
    logic [255:0] rdata = '0;
    logic         write_done = 1'b0;
    logic         read_done = 1'b0;
    logic         busy;
    logic         done;
    logic [15:0]  pass_count;
    logic [15:0]  mismatch_count;
    logic [31:0]  first_fail_addr;
    logic         timeout;

    always #5 clk = ~clk;

    wb_fuzz_driver #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .seed(seed_i),
        .num_pairs(num_pairs_i),
        .ext_master_req(req),
        .ext_master_we(we),
        .ext_master_addr_write(addr_w),
        .ext_master_addr_read(addr_r),
        .ext_master_wdata(wdata),
        .ext_master_rdata(rdata),
        .ext_master_write_done(write_done),
        .ext_master_read_done(read_done),
        .busy(busy),
        .done(done),
        .pass_count(pass_count),
        .mismatch_count(mismatch_count),
        .first_fail_addr(first_fail_addr),
        .timeout(timeout)
    );

    // bridge model behaviour knobs
    bit flip_mode  = 1'b0;
    bit stale_mode = 1'b0;
    bit no_wr_mode = 1'b0;

    logic [31:0]  mem_addr = '0;
    logic [255:0] mem_data = '0;
    logic [31:0]  rd_addr  = '0;
    int           wr_cnt   = 0;
    int           rd_cnt   = 0;

    function automatic logic [255:0] rev_beats(input logic [255:0] w);
        logic [255:0] r;
        for (int i = 0; i < 8; i++)
            r[(7-i)*32 +: 32] = w[i*32 +: 32];
        return r;
    endfunction

    // Bridge: done levels cleared on the req edge, set LAT edges later.
    always @(posedge clk) begin
        if (req) begin
            if (we) begin
                mem_addr   <= addr_w;
                mem_data   <= wdata;
                write_done <= 1'b0;
                if (!stale_mode)
                    read_done <= 1'b0;
                wr_cnt <= no_wr_mode ? 0 : LAT;
            end else begin
                write_done <= 1'b0;
                read_done  <= 1'b0;
                rd_addr    <= addr_r;
                rdata      <= '0;
                rd_cnt     <= LAT;
            end
        end else begin
            if (wr_cnt != 0) begin
                wr_cnt <= wr_cnt - 1;
                if (wr_cnt == 1)
                    write_done <= 1'b1;
            end
            if (rd_cnt != 0) begin
                rd_cnt <= rd_cnt - 1;
                if (rd_cnt == 1) begin
                    read_done <= 1'b1;
                    rdata <= ((rd_addr == mem_addr) ? rev_beats(mem_data) : '0)
                             ^ (flip_mode ? (256'h1 << 128) : 256'h0);
                end
            end
        end
    end

    // request monitor
    int           req_cnt = 0;
    bit           first_seen = 1'b0;
    logic [31:0]  first_aw = '0;
    logic [31:0]  first_ar = '0;
    logic [255:0] first_wd = '0;

    always @(negedge clk) begin
        if (req) begin
            req_cnt = req_cnt + 1;
            if (we && !first_seen) begin
                first_seen = 1'b1;
                first_aw   = addr_w;
                first_ar   = addr_r;
                first_wd   = wdata;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] step32(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic ref_first(input logic [31:0] sd, output logic [31:0] a,
                             output logic [255:0] wd);
        logic [31:0] s;
        s = (sd == 0) ? 32'h1 : sd;
        wd = '0;
        for (int k = 0; k < 8; k++) begin
            s = step32(s);
            wd[k*32 +: 32] = s;
        end
        a = 32'h3000_0000 | (s & 32'h0000_0FFF & ~32'h1F);
    endtask

    task automatic pulse_start(input logic [31:0] sd, input logic [15:0] n);
        @(negedge clk);
        seed_i      = sd;
        num_pairs_i = n;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s done_wait actual 0 required 1", name);
        end
    endtask

    typedef struct {
        logic [31:0] seed;
        logic [15:0] n;
        bit          flip;
        bit          stale;
        logic [15:0] exp_pass;
        logic [15:0] exp_mis;
    } vec_t;

    vec_t vec [5];

    logic [31:0]  ea;
    logic [255:0] ewd;
    int           cyc;
    int           snap;

    initial begin
        vec[0] = '{32'h0000_0000, 16'd1, 1'b0, 1'b0, 16'd1, 16'd0};
        vec[1] = '{32'h0000_0000, 16'd4, 1'b1, 1'b0, 16'd0, 16'd4};
        vec[2] = '{32'hDEAD_BEEF, 16'd5, 1'b0, 1'b0, 16'd5, 16'd0};
        vec[3] = '{32'h1234_5678, 16'd3, 1'b0, 1'b1, 16'd3, 16'd0};
        vec[4] = '{32'h0000_0001, 16'd2, 1'b1, 1'b0, 16'd0, 16'd2};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ctl", {req, we, busy, done, timeout}, 5'b0);
        chk("reset_cnt", {pass_count, mismatch_count}, 32'h0);
        chk("reset_addr", {addr_w, addr_r, first_fail_addr}, 96'h0);
        chk("reset_wdata", wdata, 256'h0);

        for (int v = 0; v < 5; v++) begin
            flip_mode  = vec[v].flip;
            stale_mode = vec[v].stale;
            no_wr_mode = 1'b0;
            ref_first(vec[v].seed, ea, ewd);
            req_cnt    = 0;
            first_seen = 1'b0;
            pulse_start(vec[v].seed, vec[v].n);
            wait_done($sformatf("vec%0d", v));
            @(negedge clk);
            chk($sformatf("vec%0d_done", v), {done, busy}, 2'b10);
            chk($sformatf("vec%0d_pass", v), pass_count, vec[v].exp_pass);
            chk($sformatf("vec%0d_mis", v), mismatch_count, vec[v].exp_mis);
            chk($sformatf("vec%0d_tmo", v), timeout, 1'b0);
            chk($sformatf("vec%0d_reqs", v), req_cnt, 2 * vec[v].n);
            chk($sformatf("vec%0d_aw", v), first_aw, ea);
            chk($sformatf("vec%0d_ar", v), first_ar, ea);
            chk($sformatf("vec%0d_wd", v), first_wd, ewd);
            chk($sformatf("vec%0d_ffa", v), first_fail_addr,
                vec[v].flip ? ea : 32'h0);
            if (vec[v].seed <= 1) begin
                chk($sformatf("vec%0d_w0", v), first_wd[31:0], 32'h8020_0003);
                chk($sformatf("vec%0d_w1", v), first_wd[63:32], 32'hC030_0002);
            end
            if (vec[v].flip)
                chk($sformatf("vec%0d_ffa_rng", v),
                    (first_fail_addr >= 32'h3000_0000) &&
                    (first_fail_addr <= 32'h3000_0FE0) &&
                    (first_fail_addr[4:0] == 5'h0), 1'b1);
        end

        // write_done never returns
        flip_mode  = 1'b0;
        stale_mode = 1'b0;
        no_wr_mode = 1'b1;
        req_cnt    = 0;
        pulse_start(32'h0000_0007, 16'd3);
        cyc = 0;
        while (!req && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_req_seen", req, 1'b1);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_latency", cyc, 17);
        chk("tmo_flags", {timeout, done, busy}, 3'b110);
        chk("tmo_cnt", {pass_count, mismatch_count}, 32'h0);
        repeat (10) @(negedge clk);
        chk("tmo_reqs", req_cnt, 1);
        no_wr_mode = 1'b0;

        // start while busy is ignored
        ref_first(32'hCAFE_F00D, ea, ewd);
        req_cnt    = 0;
        first_seen = 1'b0;
        pulse_start(32'hCAFE_F00D, 16'd3);
        repeat (20) @(negedge clk);
        pulse_start(32'h5555_AAAA, 16'd1);
        chk("dist_busy", {busy, done}, 2'b10);
        wait_done("dist");
        @(negedge clk);
        chk("dist_pass", pass_count, 16'd3);
        chk("dist_tmo", timeout, 1'b0);
        chk("dist_reqs", req_cnt, 6);
        chk("dist_aw", first_aw, ea);

        // reset in RD_WAIT aborts the run
        req_cnt = 0;
        pulse_start(32'h0BAD_1DEA, 16'd3);
        cyc = 0;
        while (!(req && !we) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_rdreq_seen", {req, we}, 2'b10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ctl", {req, we, busy, done, timeout}, 5'b0);
        chk("rst_cnt", {pass_count, mismatch_count}, 32'h0);
        chk("rst_addr", {addr_w, addr_r, first_fail_addr}, 96'h0);
        chk("rst_wdata", wdata, 256'h0);
        snap = req_cnt;
        repeat (40) @(negedge clk);
        chk("rst_no_req", req_cnt, snap);

        // zero pairs: done one cycle after start, no req
        req_cnt = 0;
        chk("zero_pre_done", done, 1'b0);
        pulse_start(32'h0000_0005, 16'd0);
        chk("zero_done", {done, busy}, 2'b10);
        repeat (10) @(negedge clk);
        chk("zero_reqs", req_cnt, 0);
        chk("zero_cnt", {pass_count, mismatch_count}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
